// File: rtl/qdr_req_pkg.sv
// qdr_req_queue shared types: FSM states, entry layout, counter width.
// Optional build feature: QDR_REQ_QUEUE_STATS_EN.
package qdr_req_pkg;

  typedef enum logic {
    WAIT_RDY = 1'b0,
    RUN      = 1'b1
  } state_t;

  localparam int OUT_W  = 8;
  localparam int WR_BIT = 0;

  // entry = {addr, data, be, wr}
  function automatic int entry_w(
    input int aw,
    input int dw,
    input int bw
  );
    return 1 + aw + 2*dw + 2*bw;
  endfunction

  localparam int ENTRY_W = entry_w(21, 18, 2);

endpackage

// File: rtl/qdr_req_queue_if.sv
// Client request, controller user port and status bundle.
// Optional build feature: QDR_REQ_QUEUE_STATS_EN (stat_* ports).
interface qdr_req_queue_if #(
  parameter int DATA_WIDTH = 18,
  parameter int BW_WIDTH   = 2,
  parameter int ADDR_WIDTH = 21
);
  logic                    phy_rdy;
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_wr;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [2*DATA_WIDTH-1:0] req_data;
  logic [2*BW_WIDTH-1:0]   req_be;
  logic                    usr_rd_strb;
  logic                    usr_wr_strb;
  logic [ADDR_WIDTH-1:0]   usr_addr;
  logic [2*DATA_WIDTH-1:0] usr_wr_data;
  logic [2*BW_WIDTH-1:0]   usr_wr_be;
  logic [2*DATA_WIDTH-1:0] usr_rd_data;
  logic                    usr_rd_dvld;
  logic                    rsp_valid;
  logic [2*DATA_WIDTH-1:0] rsp_data;
  logic [7:0]              rd_outstanding;
  logic                    err_underflow;
  logic [31:0]             stat_rd_count;
  logic [31:0]             stat_wr_count;

  modport master (
    output phy_rdy, req_valid, req_wr,
    output req_addr, req_data, req_be,
    output usr_rd_data, usr_rd_dvld,
    input  req_ready, usr_rd_strb, usr_wr_strb,
    input  usr_addr, usr_wr_data, usr_wr_be,
    input  rsp_valid, rsp_data, rd_outstanding,
    input  err_underflow,
    input  stat_rd_count, stat_wr_count
  );

  modport slave (
    input  phy_rdy, req_valid, req_wr,
    input  req_addr, req_data, req_be,
    input  usr_rd_data, usr_rd_dvld,
    output req_ready, usr_rd_strb, usr_wr_strb,
    output usr_addr, usr_wr_data, usr_wr_be,
    output rsp_valid, rsp_data, rd_outstanding,
    output err_underflow,
    output stat_rd_count, stat_wr_count
  );
endinterface

// File: rtl/qdr_req_fifo.sv
// First-word-fall-through synchronous FIFO, async active-high reset.
// Used by qdr_req_queue (feature macro QDR_REQ_QUEUE_STATS_EN unused here).
module qdr_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wp[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)
        wp <= wp + ONE;
      if (pop && !empty)
        rp <= rp + ONE;
    end
  end
endmodule

// File: rtl/qdr_req_queue.sv
// QDR request queue: command FIFO, gated issue, read tracking.
// Define QDR_REQ_QUEUE_STATS_EN to build the issued-command counters.
module qdr_req_queue
  import qdr_req_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int BW_WIDTH   = 2,
  parameter int ADDR_WIDTH = 21,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_RD_OUT = 15
) (
  input logic            clk0,
  input logic            reset,
  qdr_req_queue_if.slave bus
);
  localparam int EW = entry_w(ADDR_WIDTH, DATA_WIDTH, BW_WIDTH);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_RD_OUT);

  state_t           state;
  state_t           state_nx;
  logic [EW-1:0]    din;
  logic [EW-1:0]    head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             head_wr;
  logic             rd_issue;
  logic [OUT_W-1:0] rd_out;

  assign bus.req_ready      = !reset && !full;
  assign push               = bus.req_valid && bus.req_ready;
  assign din                = {bus.req_addr, bus.req_data,
                               bus.req_be, bus.req_wr};
  assign head_wr            = head[WR_BIT];
  assign rd_issue           = pop && !head_wr;
  assign bus.rd_outstanding = rd_out;

  qdr_req_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk0),
    .rst   (reset),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // a blocked read at the head also holds back later writes
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      WAIT_RDY: begin
        if (bus.phy_rdy)
          state_nx = RUN;
      end
      RUN: begin
        if (!bus.phy_rdy)
          state_nx = WAIT_RDY;
        else
          pop = !empty && (head_wr || rd_out < MAX_OUT);
      end
      default: state_nx = WAIT_RDY;
    endcase
  end

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      state             <= WAIT_RDY;
      bus.usr_rd_strb   <= 1'b0;
      bus.usr_wr_strb   <= 1'b0;
      bus.usr_addr      <= '0;
      bus.usr_wr_data   <= '0;
      bus.usr_wr_be     <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_data      <= '0;
      bus.err_underflow <= 1'b0;
      rd_out            <= '0;
    end else begin
      state           <= state_nx;
      bus.usr_rd_strb <= rd_issue;
      bus.usr_wr_strb <= pop && head_wr;
      if (pop) begin
        bus.usr_addr    <= head[EW-1 -: ADDR_WIDTH];
        bus.usr_wr_data <= head[2*BW_WIDTH+1 +: 2*DATA_WIDTH];
        bus.usr_wr_be   <= head[1 +: 2*BW_WIDTH];
      end
      bus.rsp_valid <= bus.usr_rd_dvld;
      bus.rsp_data  <= bus.usr_rd_data;
      unique case ({rd_issue, bus.usr_rd_dvld})
        2'b10: rd_out <= rd_out + 8'd1;
        2'b01: begin
          if (rd_out == '0)
            bus.err_underflow <= 1'b1;
          else
            rd_out <= rd_out - 8'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef QDR_REQ_QUEUE_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_issue)
        rd_cnt <= rd_cnt + 32'd1;
      if (pop && head_wr)
        wr_cnt <= wr_cnt + 32'd1;
    end
  end

  assign bus.stat_rd_count = rd_cnt;
  assign bus.stat_wr_count = wr_cnt;
`else
  assign bus.stat_rd_count = '0;
  assign bus.stat_wr_count = '0;
`endif
endmodule

// File: doc/qdr_req_queue.md
# qdr_req_queue

Request-queueing front end placed directly upstream of the QDR controller's user port. Accepts read/write requests from a client over a valid/ready handshake, buffers them in a command FIFO, and issues at most one strobe per cycle to the controller once the PHY reports ready. Tracks outstanding reads and registers returned read data onto a response port. Enforces a bound on in-flight reads and flags protocol errors.

## Interface
- DATA_WIDTH, 18, QDR data width; user words are 2*DATA_WIDTH
- BW_WIDTH, 2, byte-enable width; user enables are 2*BW_WIDTH
- ADDR_WIDTH, 21, burst address width
- FIFO_DEPTH, 8, command FIFO entries; power of two, ≥2
- MAX_RD_OUT, 15, maximum reads issued and not yet returned; 1..255
- clk0  in  1  single clock, same domain as controller user port
- reset  in  1  asynchronous, active-high
- phy_rdy  in  1  controller calibrated/ready
- req_valid  in  1  request present
- req_ready  out  1  queue can accept
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  request address
- req_data  in  2*DATA_WIDTH  write data (ignored for reads)
- req_be  in  2*BW_WIDTH  write byte enables, passed through unmodified
- usr_rd_strb, usr_wr_strb  out  1  strobes to controller
- usr_addr  out  ADDR_WIDTH; usr_wr_data  out  2*DATA_WIDTH; usr_wr_be  out  2*BW_WIDTH
- usr_rd_data  in  2*DATA_WIDTH; usr_rd_dvld  in  1  read return from controller
- rsp_valid  out  1; rsp_data  out  2*DATA_WIDTH  read response, no backpressure
- rd_outstanding  out  8  in-flight read count
- err_underflow  out  1  sticky: dvld seen with zero outstanding
- stat_rd_count, stat_wr_count  out  32  issued-command counters (see Configuration)

## Operation
- Reset: all outputs 0; FIFO empty; rd_outstanding 0; FSM in WAIT_RDY. req_ready is 0 during reset, 1 after.
- Accept: request enters FIFO on clk0 edge with req_valid & req_ready. req_ready = FIFO not full; no push while full, even with a pop in the same cycle.
- FSM WAIT_RDY: no issue. Go to RUN when phy_rdy = 1.
- FSM RUN: go to WAIT_RDY when phy_rdy = 0. Issue is stopped for that cycle. FIFO contents are held, not dropped.
- Issue (RUN only): head of FIFO pops when FIFO is non-empty and either (head is a write) or (rd_outstanding < MAX_RD_OUT). A read at the head that is blocked also blocks later writes (strict order).
- On pop: next cycle drive usr_rd_strb or usr_wr_strb = 1 for exactly one cycle, with usr_addr/usr_wr_data/usr_wr_be from the entry. When idle, strobes are 0 and the other usr_* outputs hold their last values.
- rd_outstanding: +1 on read issue, −1 on usr_rd_dvld. Both in the same cycle: unchanged. dvld at 0: count stays 0 and err_underflow sets. Cleared only by reset.
- Response: rsp_valid/rsp_data = usr_rd_dvld/usr_rd_data registered once. The consumer must accept every cycle.
- Reset mid-operation: FIFO contents and outstanding reads are discarded. Later dvld pulses from the controller set err_underflow.

## Timing
- Request accepted at edge N → earliest strobe asserted in cycle N+2 (FIFO write at N, pop decision in N+1, registered strobe in N+2).
- Sustained throughput: 1 command/cycle while unblocked. A full FIFO deasserts req_ready the cycle after the last free slot fills.
- Read-return latency through block: 1 cycle (dvld at edge M → rsp_valid at M+1).
- rd_outstanding updates on the same edge as the strobe register.

## Configuration
- QDR_REQ_QUEUE_STATS_EN defined: stat_rd_count/stat_wr_count increment on each issued read/write strobe, wrap modulo 2^32, reset to 0.
- Undefined: both ports are tied to 0 and no counter logic is built. Ports exist in both cases.

## Structure
- Shared package qdr_req_pkg holds the FSM state encodings (WAIT_RDY, RUN), the command entry width, the bit position of the write flag in an entry, and the rd_outstanding width (8).
- One sub-module: qdr_req_fifo — synchronous FIFO with first-word-fall-through, parameterized by width/depth, with full/empty flags and asynchronous reset.

## Test plan
- Startup gating: queue 3 writes with phy_rdy = 0 → no strobes; raise phy_rdy at cycle 20 → usr_wr_strb pulses 3 consecutive cycles starting cycle 22 with addresses in order.
- Full FIFO: FIFO_DEPTH = 8, phy_rdy = 0, present 10 requests → exactly 8 accepted, req_ready = 0; raise phy_rdy → ready returns after first pop.
- Read limit: MAX_RD_OUT = 15, issue 20 reads with no dvld → 15 usr_rd_strb, rd_outstanding = 15, a write queued behind them is also blocked. One dvld → one more read issues.
- Simultaneous issue and return: read strobe and dvld in the same cycle at count 5 → count stays 5. rsp_data equals usr_rd_data one cycle later.
- Underflow: dvld after reset with nothing issued → err_underflow = 1 and stays 1 until reset.
- PHY drop: phy_rdy falls mid-stream with 4 entries queued → strobes stop the next cycle; the remaining 4 issue in order after phy_rdy returns.
